// File: rtl/mem_arbiter_if.sv
// Purpose: bundles the IF/MEM requester ports and the byte-wide RAM port of mem_arbiter.
// Latency: none (wires only).
// Backpressure: requests are held until their done pulse; rdy low freezes the arbiter.
// Ports: rdy, flush, if_* (fetch), mem_* (load/store), ram_* (byte RAM), busy.
//   master modport = requester/RAM side, slave modport = arbiter side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic              flush;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;

    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic              busy;

    modport master (
        output rdy, flush,
        output if_req, if_addr,
        output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        output ram_din,
        input  if_done, if_data, mem_done, mem_rdata,
        input  ram_dout, ram_a, ram_wr, busy
    );

    modport slave (
        input  rdy, flush,
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        input  ram_din,
        output if_done, if_data, mem_done, mem_rdata,
        output ram_dout, ram_a, ram_wr, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares one byte-wide RAM port between IF fetches and MEM loads/stores (MEM has priority).
// Latency: read of n bytes -> done in T0+n+2; store of n bytes -> done in T0+n+1.
// Backpressure: rdy low freezes all state and blocks RAM writes; requests held until done.
// Ports: clk, rst (sync, active-high); bus (mem_arbiter_if.slave) carries rdy, flush,
//   if_req/if_addr/if_done/if_data, mem_req/we/len/addr/wdata/done/rdata,
//   ram_din/ram_dout/ram_a/ram_wr and busy.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic [2:0]        cnt_q;
    logic [2:0]        nbytes_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        dout_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf_q;
    logic [31:0]       rbuf_nxt;
    logic [31:0]       if_data_q;
    logic [31:0]       mem_rdata_q;

    logic grant_mem, grant_if;
    logic last_rd, last_wr, flush_rd;

    assign grant_mem = (state_q == IDLE) && bus.mem_req;
    // A fetch presented together with a redirect is already stale.
    assign grant_if  = (state_q == IDLE) && !bus.mem_req && bus.if_req && !bus.flush;
    // Reads run one extra cycle: byte k arrives the cycle after its address.
    assign last_rd   = (cnt_q == nbytes_q);
    assign last_wr   = (cnt_q == nbytes_q - 3'd1);
    assign flush_rd  = (state_q == READ) && (owner_q == OWN_IF) && bus.flush;

    // ram_din in the cycle with cnt=k carries byte k-1.
    always_comb begin
        rbuf_nxt = rbuf_q;
        case (cnt_q)
            3'd1:    rbuf_nxt[7:0]   = bus.ram_din;
            3'd2:    rbuf_nxt[15:8]  = bus.ram_din;
            3'd3:    rbuf_nxt[23:16] = bus.ram_din;
            3'd4:    rbuf_nxt[31:24] = bus.ram_din;
            default: rbuf_nxt = rbuf_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_mem)
                    state_d = bus.mem_we ? WRITE : READ;
                else if (grant_if)
                    state_d = READ;
            end
            READ: begin
                if (flush_rd)
                    state_d = IDLE;
                else if (last_rd)
                    state_d = DONE;
            end
            WRITE: begin
                if (last_wr)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= 3'd0;
            nbytes_q    <= 3'd0;
            addr_q      <= '0;
            dout_q      <= 8'd0;
            wdata_q     <= 32'd0;
            rbuf_q      <= 32'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else if (bus.rdy) begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (grant_mem) begin
                        owner_q <= OWN_MEM;
                        cnt_q   <= 3'd0;
                        addr_q  <= bus.mem_addr;
                        wdata_q <= bus.mem_wdata;
                        dout_q  <= bus.mem_wdata[7:0];
                        rbuf_q  <= 32'd0;
                        case (bus.mem_len)
                            2'd0:    nbytes_q <= 3'd1;
                            2'd1:    nbytes_q <= 3'd2;
                            default: nbytes_q <= 3'd4;
                        endcase
                    end else if (grant_if) begin
                        owner_q  <= OWN_IF;
                        cnt_q    <= 3'd0;
                        addr_q   <= bus.if_addr;
                        nbytes_q <= 3'd4;
                        rbuf_q   <= 32'd0;
                    end
                end
                READ: begin
                    cnt_q  <= cnt_q + 3'd1;
                    addr_q <= addr_q + 1'b1;
                    rbuf_q <= rbuf_nxt;
                    if (last_rd && !flush_rd) begin
                        if (owner_q == OWN_IF)
                            if_data_q <= rbuf_nxt;
                        else
                            mem_rdata_q <= rbuf_nxt;
                    end
                end
                WRITE: begin
                    cnt_q  <= cnt_q + 3'd1;
                    addr_q <= addr_q + 1'b1;
                    case (cnt_q)
                        3'd0:    dout_q <= wdata_q[15:8];
                        3'd1:    dout_q <= wdata_q[23:16];
                        3'd2:    dout_q <= wdata_q[31:24];
                        default: dout_q <= dout_q;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // While frozen in READ, present the address of the byte still awaiting capture,
    // so ram_din carries the right byte on the first cycle after rdy returns.
    assign bus.ram_a     = ((state_q == READ) && !bus.rdy) ? addr_q - 1'b1 : addr_q;
    assign bus.ram_dout  = dout_q;
    assign bus.ram_wr    = (state_q == WRITE) && bus.rdy;
    assign bus.if_done   = (state_q == DONE) && (owner_q == OWN_IF) && bus.rdy;
    assign bus.mem_done  = (state_q == DONE) && (owner_q == OWN_MEM) && bus.rdy;
    assign bus.if_data   = if_data_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter with a byte RAM model.
// Latency: checks done-pulse cycles against hand-derived T0 offsets.
// Backpressure: exercises rdy freeze, flush and synchronous reset mid-transaction.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] ram [0:1023];

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: read data reflects the previous cycle's address.
    always @(posedge clk) begin
        bus.ram_din <= ram[bus.ram_a[9:0]];
        if (bus.ram_wr)
            ram[bus.ram_a[9:0]] = bus.ram_dout;
    end

    task automatic idle_inputs();
        bus.rdy = 1'b1; bus.flush = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'd0;
        bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #4;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.ram_wr !== 1'b0) begin errors++; $display("FAIL reset_ram_wr got %b exp 0", bus.ram_wr); end
        checks++; if (bus.if_done !== 1'b0 || bus.mem_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b%b exp 00", bus.if_done, bus.mem_done); end
        checks++; if (bus.ram_a !== 32'd0 || bus.ram_dout !== 8'd0) begin errors++; $display("FAIL reset_ram got a=%h d=%h exp 0", bus.ram_a, bus.ram_dout); end
        checks++; if (bus.if_data !== 32'd0 || bus.mem_rdata !== 32'd0) begin errors++; $display("FAIL reset_data got %h %h exp 0", bus.if_data, bus.mem_rdata); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        for (int t = 0; t <= 7; t++) begin
            bus.if_req = (t <= 6); bus.if_addr = 32'h100;
            #3;
            checks++; if (bus.if_done !== (t == 6)) begin errors++; $display("FAIL fetch_done t=%0d got %b exp %b", t, bus.if_done, (t == 6)); end
            if (t >= 1 && t <= 4) begin
                checks++; if (bus.ram_a !== 32'(32'h100 + t - 1)) begin errors++; $display("FAIL fetch_addr t=%0d got %h exp %h", t, bus.ram_a, 32'(32'h100 + t - 1)); end
            end
            if (t == 6) begin
                checks++; if (bus.if_data !== 32'h00100513) begin errors++; $display("FAIL fetch_data got %h exp 00100513", bus.if_data); end
            end
            if (t == 7) begin
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fetch_idle got %b exp 0", bus.busy); end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    // Word store, optionally with a flush pulse that must be ignored.
    task automatic test_store(input logic [31:0] addr, input logic [31:0] wdata, input int flush_t, input string name);
        logic [31:0] wd;
        wd = wdata;
        for (int t = 0; t <= 6; t++) begin
            bus.mem_req = (t <= 5); bus.mem_we = 1'b1; bus.mem_len = 2'd2;
            bus.mem_addr = addr; bus.mem_wdata = wdata;
            bus.flush = (t == flush_t);
            #3;
            checks++; if (bus.ram_wr !== (t >= 1 && t <= 4)) begin errors++; $display("FAIL %s_wr t=%0d got %b exp %b", name, t, bus.ram_wr, (t >= 1 && t <= 4)); end
            checks++; if (bus.mem_done !== (t == 5)) begin errors++; $display("FAIL %s_done t=%0d got %b exp %b", name, t, bus.mem_done, (t == 5)); end
            if (t >= 1 && t <= 4) begin
                checks++;
                if (bus.ram_a !== 32'(addr + t - 1) || bus.ram_dout !== wd[8*(t-1) +: 8]) begin
                    errors++; $display("FAIL %s_byte t=%0d got %h@%h exp %h@%h", name, t, bus.ram_dout, bus.ram_a, wd[8*(t-1) +: 8], 32'(addr + t - 1));
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            checks++; if (ram[addr[9:0] + 10'(k)] !== wd[8*k +: 8]) begin errors++; $display("FAIL %s_ram k=%0d got %h exp %h", name, k, ram[addr[9:0] + 10'(k)], wd[8*k +: 8]); end
        end
    endtask

    task automatic test_contention();
        for (int t = 0; t <= 11; t++) begin
            bus.mem_req = (t <= 3); bus.mem_we = 1'b0; bus.mem_len = 2'd0; bus.mem_addr = 32'h30;
            bus.if_req = (t <= 10); bus.if_addr = 32'h0;
            #3;
            checks++; if (bus.mem_done !== (t == 3)) begin errors++; $display("FAIL cont_mem_done t=%0d got %b exp %b", t, bus.mem_done, (t == 3)); end
            checks++; if (bus.if_done !== (t == 10)) begin errors++; $display("FAIL cont_if_done t=%0d got %b exp %b", t, bus.if_done, (t == 10)); end
            if (t == 3) begin
                checks++; if (bus.mem_rdata !== 32'h00000080) begin errors++; $display("FAIL cont_rdata got %h exp 00000080", bus.mem_rdata); end
            end
            if (t == 5) begin
                checks++; if (bus.ram_a !== 32'h0) begin errors++; $display("FAIL cont_if_addr got %h exp 0", bus.ram_a); end
            end
            if (t == 10) begin
                checks++; if (bus.if_data !== 32'hA6A7A4A5) begin errors++; $display("FAIL cont_if_data got %h exp a6a7a4a5", bus.if_data); end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_half_load();
        for (int t = 0; t <= 5; t++) begin
            bus.mem_req = (t <= 4); bus.mem_we = 1'b0; bus.mem_len = 2'd1; bus.mem_addr = 32'h31;
            #3;
            checks++; if (bus.mem_done !== (t == 4)) begin errors++; $display("FAIL half_done t=%0d got %b exp %b", t, bus.mem_done, (t == 4)); end
            if (t == 4) begin
                checks++; if (bus.mem_rdata !== 32'h00009794) begin errors++; $display("FAIL half_rdata got %h exp 00009794", bus.mem_rdata); end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        for (int t = 0; t <= 11; t++) begin
            bus.if_req = (t <= 10);
            bus.if_addr = (t < 4) ? 32'h100 : 32'h200;
            bus.flush = (t == 3);
            #3;
            checks++; if (bus.if_done !== (t == 10)) begin errors++; $display("FAIL flush_done t=%0d got %b exp %b", t, bus.if_done, (t == 10)); end
            if (t == 4) begin
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", bus.busy); end
            end
            if (t == 10) begin
                checks++; if (bus.if_data !== 32'h00000093) begin errors++; $display("FAIL flush_data got %h exp 00000093", bus.if_data); end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_rdy_stall();
        for (int t = 0; t <= 10; t++) begin
            bus.if_req = (t <= 9); bus.if_addr = 32'h100;
            bus.rdy = !(t >= 2 && t <= 4);
            #3;
            checks++; if (bus.if_done !== (t == 9)) begin errors++; $display("FAIL stall_done t=%0d got %b exp %b", t, bus.if_done, (t == 9)); end
            checks++; if (bus.ram_wr !== 1'b0) begin errors++; $display("FAIL stall_wr t=%0d got %b exp 0", t, bus.ram_wr); end
            if (t == 9) begin
                checks++; if (bus.if_data !== 32'h00100513) begin errors++; $display("FAIL stall_data got %h exp 00100513", bus.if_data); end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_store();
        for (int t = 0; t <= 6; t++) begin
            bus.mem_req = (t <= 2); bus.mem_we = 1'b1; bus.mem_len = 2'd2;
            bus.mem_addr = 32'h50; bus.mem_wdata = 32'hCAFEF00D;
            rst = (t == 2);
            #3;
            checks++; if (bus.mem_done !== 1'b0) begin errors++; $display("FAIL rst_done t=%0d got %b exp 0", t, bus.mem_done); end
            if (t == 3) begin
                checks++; if (bus.ram_wr !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_state got wr=%b busy=%b exp 0 0", bus.ram_wr, bus.busy); end
                checks++; if (bus.mem_rdata !== 32'd0 || bus.if_data !== 32'd0) begin errors++; $display("FAIL rst_data got %h %h exp 0", bus.mem_rdata, bus.if_data); end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        checks++; if (ram[10'h50] !== 8'h0D || ram[10'h51] !== 8'hF0) begin errors++; $display("FAIL rst_partial got %h %h exp 0d f0", ram[10'h50], ram[10'h51]); end
        checks++; if (ram[10'h52] !== 8'hF7) begin errors++; $display("FAIL rst_untouched got %h exp f7", ram[10'h52]); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'(i) ^ 8'hA5;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h10; ram[10'h103] = 8'h00;
        ram[10'h030] = 8'h80;
        ram[10'h200] = 8'h93; ram[10'h201] = 8'h00; ram[10'h202] = 8'h00; ram[10'h203] = 8'h00;

        test_reset();
        test_fetch();
        test_store(32'h20, 32'hDEADBEEF, -1, "store");
        test_contention();
        test_half_load();
        test_flush();
        test_store(32'h40, 32'h11223344, 2, "flush_store");
        test_rdy_stall();
        test_reset_mid_store();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
